// File: rtl/rand_pool_arbiter.sv
// rand_pool_arbiter: round-robin grant of a random-source pool with per-source cooldown; optional stall counter under RAND_POOL_STALL_CNT_EN
module rand_pool_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int NUM_RANDS = 5,
    parameter int DATA_OUT_SIZE = 7,
    parameter int COOLDOWN = 2,
    localparam int GW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1,
    localparam int SW = NUM_RANDS > 1 ? $clog2(NUM_RANDS) : 1,
    localparam int CW = COOLDOWN > 0 ? $clog2(COOLDOWN + 1) : 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_RANDS*DATA_OUT_SIZE-1:0] in,
    input  logic [NUM_REQ-1:0]                 req,
    output logic [NUM_REQ-1:0]                 ack,
    output logic [DATA_OUT_SIZE-1:0]           rand_out,
    output logic                               rand_valid,
`ifdef RAND_POOL_STALL_CNT_EN
    output logic [15:0]                        stall_cnt,
`endif
    output logic [GW-1:0]                      grant_id
);
    logic [GW-1:0] rr_ptr, g, g_off;
    logic [SW-1:0] src_ptr, s, s_off;
    logic [GW:0] g_sum;
    logic [SW:0] s_sum;
    logic [CW-1:0] cd [NUM_RANDS];
    logic [DATA_OUT_SIZE-1:0] slice [NUM_RANDS];
    logic [NUM_REQ-1:0] elig;
    logic [NUM_RANDS-1:0] avail;
    logic [2*NUM_REQ-1:0] elig_rot;
    logic [2*NUM_RANDS-1:0] avail_rot;
    logic g_hit, s_hit, grant;

    // rotate eligibility/availability to the pointers, pick the first set bit, then unrotate with a compare-based wrap
    always_comb begin
        elig = req & ~ack;
        for (int k = 0; k < NUM_RANDS; k++) begin
            avail[k] = cd[k] == '0;
            slice[k] = in[k*DATA_OUT_SIZE +: DATA_OUT_SIZE];
        end
        elig_rot = {elig, elig} >> rr_ptr;
        avail_rot = {avail, avail} >> src_ptr;
        g_hit = 1'b0;
        g_off = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (elig_rot[j]) begin
                g_hit = 1'b1;
                g_off = GW'(j);
            end
        end
        s_hit = 1'b0;
        s_off = '0;
        for (int j = NUM_RANDS - 1; j >= 0; j--) begin
            if (avail_rot[j]) begin
                s_hit = 1'b1;
                s_off = SW'(j);
            end
        end
        g_sum = {1'b0, rr_ptr} + {1'b0, g_off};
        s_sum = {1'b0, src_ptr} + {1'b0, s_off};
        g = g_sum >= (GW+1)'(NUM_REQ) ? g_sum[GW-1:0] - GW'(NUM_REQ) : g_sum[GW-1:0];
        s = s_sum >= (SW+1)'(NUM_RANDS) ? s_sum[SW-1:0] - SW'(NUM_RANDS) : s_sum[SW-1:0];
        grant = g_hit & s_hit;
    end

    // register the grant, advance both pointers past the winners, load/decay cooldowns
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack <= '0;
            rand_valid <= 1'b0;
            rand_out <= '0;
            grant_id <= '0;
            rr_ptr <= '0;
            src_ptr <= '0;
            for (int k = 0; k < NUM_RANDS; k++) cd[k] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) ack[i] <= grant && g == GW'(i);
            rand_valid <= grant;
            if (grant) begin
                rand_out <= slice[s];
                grant_id <= g;
                rr_ptr <= g == GW'(NUM_REQ - 1) ? '0 : g + GW'(1);
                src_ptr <= s == SW'(NUM_RANDS - 1) ? '0 : s + SW'(1);
            end
            for (int k = 0; k < NUM_RANDS; k++)
                cd[k] <= (grant && s == SW'(k)) ? CW'(COOLDOWN) : cd[k] - CW'(cd[k] != '0);
        end
    end

`ifdef RAND_POOL_STALL_CNT_EN
    // count cycles where someone is waiting but every source is cooling, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt <= '0;
        else if (|elig && !(|avail) && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_rand_pool_arbiter.sv
// tb_rand_pool_arbiter: table vectors, corner sequences and a timestamp-based reference model for rand_pool_arbiter
module tb_rand_pool_arbiter;
    localparam int COOL = 2;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [34:0] in;
    logic [3:0] req, ack;
    logic [6:0] rand_out;
    logic rand_valid;
    logic [1:0] grant_id;
    logic [13:0] in3;
    logic [3:0] req3, ack3;
    logic [6:0] ro3;
    logic v3;
    logic g3;
`ifdef RAND_POOL_STALL_CNT_EN
    logic [15:0] sc, sc3;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rand_pool_arbiter u_dut (
        .clk(clk), .rst_n(rst_n), .in(in), .req(req), .ack(ack), .rand_out(rand_out),
        .rand_valid(rand_valid),
`ifdef RAND_POOL_STALL_CNT_EN
        .stall_cnt(sc),
`endif
        .grant_id(grant_id)
    );

    rand_pool_arbiter #(.NUM_REQ(2), .NUM_RANDS(2), .DATA_OUT_SIZE(7), .COOLDOWN(3)) u_d3 (
        .clk(clk), .rst_n(rst_n), .in(in3), .req(req3[1:0]), .ack(ack3[1:0]), .rand_out(ro3),
        .rand_valid(v3),
`ifdef RAND_POOL_STALL_CNT_EN
        .stall_cnt(sc3),
`endif
        .grant_id(g3)
    );

    typedef struct {
        bit rst;
        logic [3:0] req;
        logic [3:0] ack;
        logic v;
        logic [6:0] ro;
        logic [1:0] gid;
    } vec_t;
    vec_t tbl[$];

    // reference model state: pointers, cycle count and per-source earliest-available cycle
    int m_rr, m_sp, m_cyc;
    int m_av[5];
    logic [3:0] m_ack;
    logic m_v;
    logic [6:0] m_ro;
    logic [1:0] m_g;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic add(input bit r, input logic [3:0] q, input logic [3:0] a, input logic v, input int ro, input int gid);
        vec_t t;
        t.rst = r; t.req = q; t.ack = a; t.v = v; t.ro = ro[6:0]; t.gid = gid[1:0];
        tbl.push_back(t);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_ack", 32'(ack), 0);
        chk("rst_valid", 32'(rand_valid), 0);
        chk("rst_rand_out", 32'(rand_out), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic m_reset();
        m_rr = 0; m_sp = 0; m_cyc = 0;
        for (int k = 0; k < 5; k++) m_av[k] = 0;
        m_ack = '0; m_v = 1'b0; m_ro = '0; m_g = '0;
    endtask

    task automatic m_step(input logic [3:0] r, input logic [34:0] d);
        int g, s;
        logic [3:0] e;
        e = r & ~m_ack;
        g = -1;
        s = -1;
        for (int o = 0; o < 4; o++) if (g < 0 && e[(m_rr + o) % 4]) g = (m_rr + o) % 4;
        for (int o = 0; o < 5; o++) if (s < 0 && m_av[(m_sp + o) % 5] <= m_cyc) s = (m_sp + o) % 5;
        if (g >= 0 && s >= 0) begin
            m_ack = 4'b0001 << g;
            m_v = 1'b1;
            m_g = g[1:0];
            m_ro = d[s*7 +: 7];
            m_rr = (g + 1) % 4;
            m_sp = (s + 1) % 5;
            m_av[s] = m_cyc + COOL + 1;
        end else begin
            m_ack = '0;
            m_v = 1'b0;
        end
        m_cyc++;
    endtask

    initial begin
        logic [3:0] e3a[6];
        logic [6:0] e3r[6];
        in = {7'd14, 7'd13, 7'd12, 7'd11, 7'd10};
        in3 = {7'd6, 7'd5};
        req = '0;
        req3 = '0;
        #2;
        // single held requester: ack every other cycle, sources rotate and wrap
        add(1, 4'b0001, 4'b0001, 1, 10, 0);
        add(0, 4'b0001, 4'b0000, 0, 10, 0);
        add(0, 4'b0001, 4'b0001, 1, 11, 0);
        add(0, 4'b0001, 4'b0000, 0, 11, 0);
        add(0, 4'b0001, 4'b0001, 1, 12, 0);
        add(0, 4'b0001, 4'b0000, 0, 12, 0);
        add(0, 4'b0001, 4'b0001, 1, 13, 0);
        add(0, 4'b0001, 4'b0000, 0, 13, 0);
        add(0, 4'b0001, 4'b0001, 1, 14, 0);
        add(0, 4'b0001, 4'b0000, 0, 14, 0);
        add(0, 4'b0001, 4'b0001, 1, 10, 0);
        // all four request, each drops after its ack
        add(1, 4'b0000, 4'b0000, 0, 0, 0);
        add(0, 4'b1111, 4'b0001, 1, 10, 0);
        add(0, 4'b1110, 4'b0010, 1, 11, 1);
        add(0, 4'b1100, 4'b0100, 1, 12, 2);
        add(0, 4'b1000, 4'b1000, 1, 13, 3);
        add(0, 4'b0000, 4'b0000, 0, 13, 3);
        // requester 3 first wraps rr_ptr; src_ptr wraps after the fifth grant
        add(1, 4'b1000, 4'b1000, 1, 10, 3);
        add(0, 4'b0000, 4'b0000, 0, 10, 3);
        add(0, 4'b1001, 4'b0001, 1, 11, 0);
        add(0, 4'b1001, 4'b1000, 1, 12, 3);
        add(0, 4'b1001, 4'b0001, 1, 13, 0);
        add(0, 4'b1001, 4'b1000, 1, 14, 3);
        add(0, 4'b1001, 4'b0001, 1, 10, 0);
        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            req = tbl[i].req;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_ack", i), 32'(ack), 32'(tbl[i].ack));
            chk($sformatf("row%0d_valid", i), 32'(rand_valid), 32'(tbl[i].v));
            chk($sformatf("row%0d_rand_out", i), 32'(rand_out), 32'(tbl[i].ro));
            chk($sformatf("row%0d_grant_id", i), 32'(grant_id), 32'(tbl[i].gid));
        end

        // asynchronous reset while ack[1] is high
        do_reset();
        req = 4'b1111;
        @(posedge clk);
        #1;
        chk("mid_ack0", 32'(ack), 32'b0001);
        req = 4'b1110;
        @(posedge clk);
        #1;
        chk("mid_ack1", 32'(ack), 32'b0010);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_ack", 32'(ack), 0);
        chk("async_valid", 32'(rand_valid), 0);
        chk("async_rand_out", 32'(rand_out), 0);
        chk("async_grant_id", 32'(grant_id), 0);
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'b0100;
        @(posedge clk);
        #1;
        chk("post_rst_ack", 32'(ack), 32'b0100);
        chk("post_rst_rand_out", 32'(rand_out), 10);
        chk("post_rst_grant_id", 32'(grant_id), 2);
        req = '0;

        // two sources with cooldown 3 and two held requesters
        e3a = '{4'b01, 4'b10, 4'b00, 4'b00, 4'b01, 4'b10};
        e3r = '{7'd5, 7'd6, 7'd6, 7'd6, 7'd5, 7'd6};
        do_reset();
        req3 = 4'b0011;
        for (int t = 0; t < 6; t++) begin
            @(posedge clk);
            #1;
            chk($sformatf("cd3_ack_t%0d", t), 32'(ack3[1:0]), 32'(e3a[t]));
            chk($sformatf("cd3_rand_out_t%0d", t), 32'(ro3), 32'(e3r[t]));
        end
`ifdef RAND_POOL_STALL_CNT_EN
        chk("cd3_stall_cnt", 32'(sc3), 2);
`endif
        req3 = '0;

        // randomized traffic against the reference model
        do_reset();
        m_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (req[i] && !m_ack[i]) req[i] = 1'b1;
                else if (m_ack[i]) req[i] = $urandom_range(1) == 1;
                else req[i] = $urandom_range(2) == 0;
            end
            in = 35'({$urandom(), $urandom()});
            m_step(req, in);
            @(posedge clk);
            #1;
            chk($sformatf("rnd%0d_ack", c), 32'(ack), 32'(m_ack));
            chk($sformatf("rnd%0d_valid", c), 32'(rand_valid), 32'(m_v));
            chk($sformatf("rnd%0d_rand_out", c), 32'(rand_out), 32'(m_ro));
            chk($sformatf("rnd%0d_grant_id", c), 32'(grant_id), 32'(m_g));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
